// File: rtl/rf_wb_pkg.sv
// rf_wb_pkg: shared types and constants for the register-file writeback
// arbiter (rf_wb_arbiter) and its write buffer (wb_fifo).
//   XLEN     : datapath width used by the wb_req_t payload.
//   REG_ZERO : architectural x0, never written.
//   wb_req_t : {rd, data} writeback request, used for ALU input and FIFO entries.
// The arbiter's XLEN parameter must equal XLEN here, because the FIFO entry type is fixed by this package.
package rf_wb_pkg;

    localparam int XLEN = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_arbiter_if: writeback-port bundle between the core and rf_wb_arbiter.
//   ALU source    : alu_valid/alu_ready/alu_rd/alu_data (valid/ready handshake)
//   load source   : ld_valid/ld_rd/ld_data (never stalled)
//   regfile port  : rf_we/rf_a3/rf_wd (we3/a3/wd3)
//   hazard query  : q_a1/q_a2 in, pend1/pend2/byp1/byp2 out
//   status        : occ (write-buffer occupancy)
// modport master = core side (drives requests), slave = arbiter side.
interface rf_wb_arbiter_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic             alu_valid;
    logic             alu_ready;
    logic [4:0]       alu_rd;
    logic [XLEN-1:0]  alu_data;
    logic             ld_valid;
    logic [4:0]       ld_rd;
    logic [XLEN-1:0]  ld_data;
    logic             rf_we;
    logic [4:0]       rf_a3;
    logic [XLEN-1:0]  rf_wd;
    logic [4:0]       q_a1;
    logic [4:0]       q_a2;
    logic             pend1;
    logic             pend2;
    logic [XLEN-1:0]  byp1;
    logic [XLEN-1:0]  byp2;
    logic [OCC_W-1:0] occ;

    modport master (
        output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, q_a1, q_a2,
        input  alu_ready, rf_we, rf_a3, rf_wd, pend1, pend2, byp1, byp2, occ
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, q_a1, q_a2,
        output alu_ready, rf_we, rf_a3, rf_wd, pend1, pend2, byp1, byp2, occ
    );

endinterface

// File: rtl/rf_wb_arbiter_fifo.sv
// wb_fifo: DEPTH-entry synchronous FIFO holding ALU writes that lost the
// regfile port to a load.
//   clk, reset          : clock, synchronous active-high reset (empties FIFO)
//   push, push_req      : enqueue request at the tail
//   pop                 : dequeue the head
//   head                : current head entry (valid when occ != 0)
//   occ                 : occupancy 0..DEPTH
//   view_rd / view_vld  : entries ordered oldest (index 0) to youngest
//   view_data           : matching data view, only with RF_WB_BYPASS_EN
// Caller guarantees no push when full without a simultaneous pop and no
// pop when empty.
module wb_fifo
    import rf_wb_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int OCC_W = PTR_W + 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  wb_req_t                    push_req,
    input  logic                       pop,
    output wb_req_t                    head,
    output logic [OCC_W-1:0]           occ,
    output logic [DEPTH-1:0][4:0]      view_rd,
`ifdef RF_WB_BYPASS_EN
    output logic [DEPTH-1:0][XLEN-1:0] view_data,
`endif
    output logic [DEPTH-1:0]           view_vld
);

    wb_req_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointers wrap naturally since DEPTH is a power of two. When full
    // with push and pop together, wr_ptr == rd_ptr: the head is read
    // combinationally this cycle and overwritten at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_req;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                occ <= occ + OCC_W'(1);
            else if (pop && !push)
                occ <= occ - OCC_W'(1);
        end
    end

    assign head = mem[rd_ptr];

    // Age-ordered view so match logic can pick the youngest hit by index.
    always_comb begin
        logic [PTR_W-1:0] idx;
        view_rd  = '0;
        view_vld = '0;
`ifdef RF_WB_BYPASS_EN
        view_data = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            idx         = rd_ptr + PTR_W'(k);
            view_rd[k]  = mem[idx].rd;
            view_vld[k] = OCC_W'(k) < occ;
`ifdef RF_WB_BYPASS_EN
            view_data[k] = mem[idx].data;
`endif
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the single regfile write port between the ALU
// writeback (valid/ready) and the BRAM load return (never stalled, always
// wins). ALU writes that lose are buffered in wb_fifo; pend1/pend2 tell
// the hazard unit that a queued write targets a decode read address.
//   clk, reset : clock, synchronous active-high reset
//   bus        : rf_wb_arbiter_if.slave (ALU/load sources, regfile port,
//                hazard query, occupancy)
// Port priority: load > FIFO head > ALU cut-through.
// Optional feature macro RF_WB_BYPASS_EN: byp1/byp2 forward the youngest
// queued data matching q_a1/q_a2; when undefined they are tied to 0.
module rf_wb_arbiter
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int XLEN  = rf_wb_pkg::XLEN
) (
    input  logic           clk,
    input  logic           reset,
    rf_wb_arbiter_if.slave bus
);

    localparam int OCC_W = $clog2(DEPTH) + 1;

    wb_req_t                    alu_req;
    wb_req_t                    head;
    logic [OCC_W-1:0]           occ;
    logic [DEPTH-1:0][4:0]      view_rd;
    logic [DEPTH-1:0]           view_vld;
`ifdef RF_WB_BYPASS_EN
    logic [DEPTH-1:0][XLEN-1:0] view_data;
`endif
    logic                       empty;
    logic                       full;
    logic                       ready;
    logic                       cut;
    logic                       push;
    logic                       pop;
    logic                       hit1;
    logic                       hit2;
    logic [XLEN-1:0]            byp1_d;
    logic [XLEN-1:0]            byp2_d;

    assign alu_req = {bus.alu_rd, bus.alu_data};
    assign empty   = (occ == '0);
    assign full    = (occ == OCC_W'(DEPTH));

    // A full FIFO can still accept when no load is present, because the
    // head pops in the same cycle.
    always_comb begin
        ready = !reset && (!full || !bus.ld_valid);
        cut   = !reset && !bus.ld_valid && empty && bus.alu_valid;
        pop   = !reset && !bus.ld_valid && !empty;
        push  = bus.alu_valid && ready && !cut && (bus.alu_rd != REG_ZERO);
    end

    always_comb begin
        bus.rf_we = 1'b0;
        bus.rf_a3 = REG_ZERO;
        bus.rf_wd = '0;
        if (!reset) begin
            if (bus.ld_valid) begin
                // x0 loads still consume the slot, just without a write.
                bus.rf_we = (bus.ld_rd != REG_ZERO);
                bus.rf_a3 = bus.ld_rd;
                bus.rf_wd = bus.ld_data;
            end else if (!empty) begin
                bus.rf_we = 1'b1;
                bus.rf_a3 = head.rd;
                bus.rf_wd = head.data;
            end else if (bus.alu_valid) begin
                bus.rf_we = (bus.alu_rd != REG_ZERO);
                bus.rf_a3 = bus.alu_rd;
                bus.rf_wd = bus.alu_data;
            end
        end
    end

    assign bus.alu_ready = ready;
    assign bus.occ       = occ;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_req (alu_req),
        .pop      (pop),
        .head     (head),
        .occ      (occ),
        .view_rd  (view_rd),
`ifdef RF_WB_BYPASS_EN
        .view_data(view_data),
`endif
        .view_vld (view_vld)
    );

    // Later (younger) entries override earlier ones, so the forwarded
    // value is the one that will end up in the regfile.
    always_comb begin
        hit1   = 1'b0;
        hit2   = 1'b0;
        byp1_d = '0;
        byp2_d = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (view_vld[k] && view_rd[k] == bus.q_a1) begin
                hit1 = 1'b1;
`ifdef RF_WB_BYPASS_EN
                byp1_d = view_data[k];
`endif
            end
            if (view_vld[k] && view_rd[k] == bus.q_a2) begin
                hit2 = 1'b1;
`ifdef RF_WB_BYPASS_EN
                byp2_d = view_data[k];
`endif
            end
        end
    end

    assign bus.pend1 = !reset && (bus.q_a1 != REG_ZERO) && hit1;
    assign bus.pend2 = !reset && (bus.q_a2 != REG_ZERO) && hit2;
    assign bus.byp1  = bus.pend1 ? byp1_d : '0;
    assign bus.byp2  = bus.pend2 ? byp2_d : '0;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: self-checking bench for rf_wb_arbiter (DEPTH=2).
// Each test pushes the regfile writes it expects, in commit order, onto
// exp_q; a negedge monitor pops and compares every rf_we=1 cycle and
// flags writes nobody expected. Tests check occ/ready/pend/byp inline.
module tb_rf_wb_arbiter;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;
`ifdef RF_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];

    rf_wb_arbiter_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

    rf_wb_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every commit must match the queue front.
    always @(negedge clk) begin
        exp_t e;
        if (bus.rf_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected: got a3=%0d wd=%h, required no write", bus.rf_a3, bus.rf_wd);
            end else begin
                e = exp_q.pop_front();
                if (bus.rf_a3 !== e.rd || bus.rf_wd !== e.data) begin
                    errors++;
                    $display("FAIL wr_data: got a3=%0d wd=%h, required a3=%0d wd=%h", bus.rf_a3, bus.rf_wd, e.rd, e.data);
                end
            end
        end else if (bus.rf_we !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL rf_we_x: got %b, required 0/1", bus.rf_we);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
        bus.ld_valid  = 1'b0; bus.ld_rd  = '0; bus.ld_data  = '0;
        bus.q_a1 = '0; bus.q_a2 = '0;
    endtask

    task automatic push_exp(input logic [4:0] rd, input logic [XLEN-1:0] d);
        exp_t e;
        e.rd = rd; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic ld(input logic [4:0] rd, input logic [XLEN-1:0] d);
        bus.ld_valid = 1'b1; bus.ld_rd = rd; bus.ld_data = d;
    endtask

    task automatic alu(input logic [4:0] rd, input logic [XLEN-1:0] d);
        bus.alu_valid = 1'b1; bus.alu_rd = rd; bus.alu_data = d;
    endtask

    task automatic test_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d writes outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        alu(5'd5, 32'h1234); ld(5'd6, 32'h5678); bus.q_a1 = 5'd5;
        tick(); tick();
        @(negedge clk);
        checks++; if (bus.alu_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b required 0", bus.alu_ready); end
        checks++; if (bus.occ !== 2'd0) begin errors++; $display("FAIL rst_occ: got %0d required 0", bus.occ); end
        checks++; if (bus.pend1 !== 1'b0 || bus.byp1 !== '0) begin errors++; $display("FAIL rst_pend: got pend=%b byp=%h required 0/0", bus.pend1, bus.byp1); end
        checks++; if (bus.rf_a3 !== 5'd0 || bus.rf_wd !== '0) begin errors++; $display("FAIL rst_port: got a3=%0d wd=%h required 0/0", bus.rf_a3, bus.rf_wd); end
        tick();
        reset = 1'b0;
        idle();
        tick();
    endtask

    task automatic test_cut_through();
        push_exp(5'd5, 32'hA5A5A5A5);
        alu(5'd5, 32'hA5A5A5A5); bus.q_a1 = 5'd5;
        @(negedge clk);
        checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL ct_ready: got %b required 1", bus.alu_ready); end
        checks++; if (bus.occ !== 2'd0 || bus.pend1 !== 1'b0) begin errors++; $display("FAIL ct_occ_pend: got occ=%0d pend=%b required 0/0", bus.occ, bus.pend1); end
        tick(); idle(); bus.q_a1 = 5'd5;
        @(negedge clk);
        checks++; if (bus.occ !== 2'd0 || bus.pend1 !== 1'b0) begin errors++; $display("FAIL ct_after: got occ=%0d pend=%b required 0/0", bus.occ, bus.pend1); end
        tick();
        test_drained("ct");
    endtask

    task automatic test_collision();
        push_exp(5'd3, 32'h11);
        push_exp(5'd4, 32'h22);
        ld(5'd3, 32'h11); alu(5'd4, 32'h22); bus.q_a1 = 5'd4;
        @(negedge clk);
        checks++; if (bus.alu_ready !== 1'b1 || bus.occ !== 2'd0) begin errors++; $display("FAIL col_c0: got ready=%b occ=%0d required 1/0", bus.alu_ready, bus.occ); end
        tick(); idle(); bus.q_a1 = 5'd4;
        @(negedge clk);
        checks++; if (bus.occ !== 2'd1 || bus.pend1 !== 1'b1) begin errors++; $display("FAIL col_c1: got occ=%0d pend=%b required 1/1", bus.occ, bus.pend1); end
        checks++; if (bus.byp1 !== (BYP ? 32'h22 : 32'h0)) begin errors++; $display("FAIL col_byp: got %h required %h", bus.byp1, BYP ? 32'h22 : 32'h0); end
        tick();
        @(negedge clk);
        checks++; if (bus.occ !== 2'd0 || bus.pend1 !== 1'b0) begin errors++; $display("FAIL col_c2: got occ=%0d pend=%b required 0/0", bus.occ, bus.pend1); end
        tick();
        test_drained("col");
    endtask

    task automatic test_fill();
        logic [1:0] occ_exp [4] = '{2'd2, 2'd2, 2'd1, 2'd0};
        push_exp(5'd10, 32'h100); push_exp(5'd11, 32'h101); push_exp(5'd12, 32'h102);
        push_exp(5'd20, 32'h200); push_exp(5'd21, 32'h201); push_exp(5'd22, 32'h202);
        for (int i = 0; i < 3; i++) begin
            ld(5'(10 + i), 32'h100 + i); alu(5'(20 + i), 32'h200 + i);
            @(negedge clk);
            checks++;
            if (bus.alu_ready !== (i < 2) || bus.occ !== 2'(i)) begin
                errors++;
                $display("FAIL fill_c%0d: got ready=%b occ=%0d required %b/%0d", i, bus.alu_ready, bus.occ, i < 2, i);
            end
            tick();
        end
        // rd22 was refused at occ=2; hold it until the load stops.
        bus.ld_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (bus.occ !== occ_exp[i] || bus.alu_ready !== 1'b1) begin
                errors++;
                $display("FAIL fill_drain%0d: got occ=%0d ready=%b required %0d/1", i, bus.occ, bus.alu_ready, occ_exp[i]);
            end
            tick();
            idle();
        end
        test_drained("fill");
    endtask

    task automatic test_x0();
        push_exp(5'd3, 32'h33);
        push_exp(5'd9, 32'h55);
        ld(5'd3, 32'h33); alu(5'd0, 32'h99);
        @(negedge clk);
        checks++; if (bus.alu_ready !== 1'b1 || bus.occ !== 2'd0) begin errors++; $display("FAIL x0_c0: got ready=%b occ=%0d required 1/0", bus.alu_ready, bus.occ); end
        tick(); idle();
        @(negedge clk);
        checks++; if (bus.occ !== 2'd0 || bus.pend1 !== 1'b0) begin errors++; $display("FAIL x0_c1: got occ=%0d pend=%b required 0/0", bus.occ, bus.pend1); end
        tick();
        // x0 load holds the slot; the ALU write must queue.
        ld(5'd0, 32'h44); alu(5'd9, 32'h55); bus.q_a1 = 5'd9;
        @(negedge clk);
        checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL x0_ld_ready: got %b required 1", bus.alu_ready); end
        tick(); idle(); bus.q_a1 = 5'd9;
        @(negedge clk);
        checks++; if (bus.occ !== 2'd1 || bus.pend1 !== 1'b1) begin errors++; $display("FAIL x0_c3: got occ=%0d pend=%b required 1/1", bus.occ, bus.pend1); end
        tick(); idle();
        alu(5'd0, 32'h77); bus.q_a1 = 5'd9;
        @(negedge clk);
        checks++; if (bus.alu_ready !== 1'b1 || bus.occ !== 2'd0 || bus.pend1 !== 1'b0) begin errors++; $display("FAIL x0_c4: got ready=%b occ=%0d pend=%b required 1/0/0", bus.alu_ready, bus.occ, bus.pend1); end
        tick(); idle();
        tick();
        test_drained("x0");
    endtask

    task automatic test_bypass();
        logic [1:0] occ_exp [3] = '{2'd2, 2'd1, 2'd0};
        push_exp(5'd1, 32'h10); push_exp(5'd2, 32'h20); push_exp(5'd3, 32'h30);
        push_exp(5'd7, 32'h1);  push_exp(5'd7, 32'h2);
        ld(5'd1, 32'h10); alu(5'd7, 32'h1);
        tick();
        ld(5'd2, 32'h20); alu(5'd7, 32'h2);
        tick(); idle();
        ld(5'd3, 32'h30); bus.q_a1 = 5'd7; bus.q_a2 = 5'd8;
        @(negedge clk);
        checks++; if (bus.occ !== 2'd2 || bus.pend1 !== 1'b1 || bus.pend2 !== 1'b0) begin errors++; $display("FAIL byp_pend: got occ=%0d p1=%b p2=%b required 2/1/0", bus.occ, bus.pend1, bus.pend2); end
        checks++; if (bus.byp1 !== (BYP ? 32'h2 : 32'h0) || bus.byp2 !== '0) begin errors++; $display("FAIL byp_young: got b1=%h b2=%h required %h/0", bus.byp1, bus.byp2, BYP ? 32'h2 : 32'h0); end
        tick(); idle(); bus.q_a1 = 5'd7;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.occ !== occ_exp[i] || bus.pend1 !== (i < 2) || bus.byp1 !== ((BYP && i < 2) ? 32'h2 : 32'h0)) begin
                errors++;
                $display("FAIL byp_drain%0d: got occ=%0d pend=%b byp=%h required %0d/%b/%h", i, bus.occ, bus.pend1, bus.byp1, occ_exp[i], i < 2, (BYP && i < 2) ? 32'h2 : 32'h0);
            end
            tick();
        end
        test_drained("byp");
    endtask

    task automatic test_back_to_back();
        logic [4:0]      rd;
        logic [XLEN-1:0] d;
        for (int i = 0; i < 8; i++) begin
            rd = 5'($urandom_range(1, 31));
            d  = $urandom;
            push_exp(rd, d);
            alu(rd, d);
            @(negedge clk);
            checks++;
            if (bus.alu_ready !== 1'b1 || bus.occ !== 2'd0) begin
                errors++;
                $display("FAIL b2b_%0d: got ready=%b occ=%0d required 1/0", i, bus.alu_ready, bus.occ);
            end
            tick();
        end
        idle();
        tick();
        test_drained("b2b");
    endtask

    task automatic test_reset_mid();
        // Only the loads may ever reach the regfile.
        push_exp(5'd1, 32'hAA);
        push_exp(5'd2, 32'hBB);
        ld(5'd1, 32'hAA); alu(5'd13, 32'h1);
        tick();
        ld(5'd2, 32'hBB); alu(5'd14, 32'h2);
        tick(); idle();
        reset = 1'b1; bus.q_a1 = 5'd13;
        @(negedge clk);
        checks++; if (bus.occ !== 2'd2 || bus.pend1 !== 1'b0 || bus.alu_ready !== 1'b0) begin errors++; $display("FAIL rstm_hold: got occ=%0d pend=%b ready=%b required 2/0/0", bus.occ, bus.pend1, bus.alu_ready); end
        tick();
        reset = 1'b0;
        @(negedge clk);
        checks++; if (bus.occ !== 2'd0 || bus.pend1 !== 1'b0) begin errors++; $display("FAIL rstm_after: got occ=%0d pend=%b required 0/0", bus.occ, bus.pend1); end
        tick(); tick();
        test_drained("rstm");
    endtask

    initial begin
        test_reset();
        test_cut_through();
        test_collision();
        test_fill();
        test_x0();
        test_bypass();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port (we3/a3/wd3) between two writeback sources in the pipelined BRAM core.
- Source 1 is the ALU/execute result path, which has valid/ready backpressure.
- Source 2 is the BRAM load-return path, which cannot be stalled and always wins the port.
- Losing ALU writes are held in a small FIFO. The block reports pending writes to the hazard unit so dependent reads stall or bypass.

Parameters:
- DEPTH, 2, ALU write-buffer entries (power of two, >=2).
- XLEN, 32, data width.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU writeback request.
- alu_ready  out  1  ALU request accepted this cycle.
- alu_rd  in  5  ALU destination register.
- alu_data  in  XLEN  ALU result.
- ld_valid  in  1  load-return write (never stalled).
- ld_rd  in  5  load destination register.
- ld_data  in  XLEN  load data.
- rf_we  out  1  to regfile we3.
- rf_a3  out  5  to regfile a3.
- rf_wd  out  XLEN  to regfile wd3.
- q_a1, q_a2  in  5  decode-stage read addresses.
- pend1, pend2  out  1  a queued write targets q_a1/q_a2.
- byp1, byp2  out  XLEN  youngest queued data for q_a1/q_a2 (feature only).
- occ  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset: synchronous. FIFO pointers and occ go to 0 and all entries are discarded, including mid-operation. While reset is high, rf_we=0, alu_ready=0, pend*=0 and byp*=0.
- Write-port selection is combinational; the regfile commits on negedge.
  - ld_valid=1: port = load (rf_a3=ld_rd, rf_wd=ld_data, rf_we=(ld_rd!=0)).
  - else FIFO non-empty: port = FIFO head, head pops, occ-1.
  - else alu_valid=1: port = ALU directly (cut-through, zero latency), no enqueue.
  - else rf_we=0 and rf_a3/rf_wd hold 0.
- alu_ready = !reset && (occ<DEPTH || !ld_valid). When the FIFO is full and no load is present, pop and push happen in the same cycle and occ is unchanged.
- Enqueue: happens when alu_valid && alu_ready and the ALU is not cut-through.
  - Case ld_valid=1: enqueue at the tail.
  - Case FIFO non-empty: enqueue behind the head being popped. occ is unchanged when pop and push coincide.
- x0 rule: an ALU request with alu_rd=0 is accepted (alu_ready per rule above) but never enqueued or written. A load with ld_rd=0 still occupies the port slot with rf_we=0.
- Ordering:
  - FIFO is strict FIFO, so ALU-to-ALU program order is preserved.
  - Load-vs-ALU ordering to the same rd is the hazard unit's responsibility, enforced via pend*.
  - Both sources valid with equal rd: the load writes this cycle and the ALU entry queues. The later FIFO write is the final value.
- Pointers: wrap modulo DEPTH. occ ranges 0..DEPTH. Pushing when full without a pop cannot occur, because alu_ready prevents it.
- pend1 = (q_a1!=0) && any valid FIFO entry has rd==q_a1; pend2 likewise. Evaluated on current FIFO state, combinational.
- Cut-through and load writes are not pending: they commit at the negedge of the same cycle.

Optional Feature:
- Macro: RF_WB_BYPASS_EN.
- Defined: byp1/byp2 return data of the youngest (closest to tail) valid entry matching q_a1/q_a2, and 0 when pend is 0. Decode can forward instead of stall.
- Undefined: byp1/byp2 are tied to 0 and no match-priority logic is built. Decode must stall on pend.

Decomposition:
- Package rf_wb_pkg: XLEN default, REG_ZERO=5'd0, and a packed struct wb_req_t {logic [4:0] rd; logic [XLEN-1:0] data;} used for FIFO entries and the ALU input bundle.
- One sub-module, wb_fifo: DEPTH-entry synchronous FIFO providing push/pop/occ and an entry-array view for the match logic.
- Arbitration and match logic stay in rf_wb_arbiter.

Test Plan:
- Idle ALU write: alu_valid, rd=5, data=0xA5A5A5A5, no load -> same cycle rf_we=1, a3=5, wd3=0xA5A5A5A5, occ=0, pend=0.
- Collision: ld_valid rd=3 0x11 plus alu_valid rd=4 0x22 -> cycle 0 the port writes rd3, occ=1, pend(q_a1=4)=1. Cycle 1 (no load) writes rd4=0x22, occ=0.
- Fill/backpressure, DEPTH=2: load for 3 consecutive cycles with ALU valid each cycle -> occ 1,2, then alu_ready=0 at occ=2. When the load stops, pop and push coexist and occ stays at 2 until drained.
- x0: alu_rd=0 with ld_valid=1 -> alu_ready=1, occ unchanged, no write to x0 ever, pend(q_a1=0)=0.
- Bypass (RF_WB_BYPASS_EN): queue rd7=0x1 then rd7=0x2 under load pressure -> byp1(q_a1=7)=0x2. Without the macro -> byp1=0, pend1=1.
- Reset mid-operation: occ=2 and reset pulsed one cycle -> next cycle occ=0, rf_we=0, pend=0; queued writes never reach the regfile.
